t07_ext_bus_master: RTL and testbench

- Downstream stage of the CPU memory handler: turns its one-cycle rwi request pulses into single-beat Wishbone-classic bus cycles toward external SRAM/MMIO, and reports completion by dropping busy.
- Aligns byte/half-word lanes so the handler sees read data right-justified and supplies write data right-justified.
- Fetch results go to a separate instruction register.

---
 rtl/t07_ext_bus_master.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_t07_ext_bus_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t07_ext_bus_master.sv
// ---------------------------------------------------------------------------
// t07_ext_bus_master
//   Downstream stage of the CPU memory handler. Each one-cycle rwi pulse
//   becomes one single-beat Wishbone-classic cycle toward external SRAM/MMIO.
//   Completion is reported by busy falling, exactly once per accepted request.
//   Load data is returned right-justified and zero-extended. Store data is
//   taken right-justified and replicated into the addressed byte lanes.
//   Fetch results land in a separate instruction register.
//
// Optional feature (compile-time macro TIMEOUT_EN):
//   Defined   : a BUS cycle that sees no ack within TIMEOUT_CYCLES cycles is
//               aborted. err pulses, and a read/fetch returns ERR_DATA.
//   Undefined : BUS waits indefinitely for ack; err flags misalignment only.
//
// Parameters:
//   TIMEOUT_CYCLES  max BUS cycles without ack before abort (TIMEOUT_EN only)
//   ERR_DATA        value returned on aborted or misaligned reads/fetches
//
// Ports:
//   clk, nrst         clock, synchronous active-low reset
//   rwi[1:0]          00 idle, 01 write, 10 read, 11 fetch (sampled in IDLE)
//   addr[31:0]        byte address
//   wdata[31:0]       right-justified store data
//   size[1:0]         00 byte, 01 half, 10 word (fetch is always word)
//   busy              high while a request is in flight
//   ext_data[31:0]    right-justified, zero-extended load data
//   instr[31:0]       last fetched instruction
//   instr_valid       one-cycle pulse when instr updates
//   err               one-cycle pulse on misalignment or timeout
//   wb_cyc_o/stb_o/we_o, wb_adr_o, wb_sel_o, wb_dat_o   Wishbone master side
//   wb_dat_i, wb_ack_i                                  Wishbone slave return
// ---------------------------------------------------------------------------
module t07_ext_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  rwi,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        busy,
  output logic [31:0] ext_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_FE   = 2'b11;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t      state, state_nx;

  // latched request context needed after the request pulse is gone
  logic [1:0]  op_q,   op_nx;
  logic [1:0]  size_q, size_nx;
  logic [1:0]  off_q,  off_nx;
  // stretches a misaligned completion to the same two busy cycles as a
  // zero-wait bus access, so upstream sees uniform minimum latency
  logic        hold_q, hold_nx;

  logic        busy_nx, iv_nx, err_nx;
  logic [31:0] ext_nx, instr_nx;
  logic        cyc_nx, stb_nx, we_nx;
  logic [31:0] adr_nx, dat_nx;
  logic [3:0]  sel_nx;

`ifdef TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt, to_cnt_nx;
`endif

  // -------------------------------------------------------------------------
  // Request decode (combinational on the live request inputs)
  // -------------------------------------------------------------------------
  logic [1:0]  req_sz;
  logic        req_mis;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;

  always_comb begin
    req_sz  = (rwi == OP_FE) ? SZ_W : size;
    req_mis = 1'b0;
    req_sel = 4'b1111;
    req_dat = wdata;
    case (req_sz)
      SZ_B: begin
        req_sel = 4'b0001 << addr[1:0];
        req_dat = {4{wdata[7:0]}};
      end
      SZ_H: begin
        req_sel = addr[1] ? 4'b1100 : 4'b0011;
        req_dat = {2{wdata[15:0]}};
        req_mis = addr[0];
      end
      // word, and the unused 2'b11 encoding, are handled as word
      default: req_mis = |addr[1:0];
    endcase
  end

  // -------------------------------------------------------------------------
  // Read lane extraction: selected lane(s) shifted down, upper bits zero
  // -------------------------------------------------------------------------
  logic [7:0]  rd_byte;
  logic [31:0] rd_data;

  always_comb begin
    case (off_q)
      2'd0:    rd_byte = wb_dat_i[7:0];
      2'd1:    rd_byte = wb_dat_i[15:8];
      2'd2:    rd_byte = wb_dat_i[23:16];
      default: rd_byte = wb_dat_i[31:24];
    endcase
    case (size_q)
      SZ_B:    rd_data = {24'h0, rd_byte};
      SZ_H:    rd_data = off_q[1] ? {16'h0, wb_dat_i[31:16]} : {16'h0, wb_dat_i[15:0]};
      default: rd_data = wb_dat_i;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    size_nx  = size_q;
    off_nx   = off_q;
    hold_nx  = hold_q;
    busy_nx  = busy;
    ext_nx   = ext_data;
    instr_nx = instr;
    iv_nx    = 1'b0;
    err_nx   = 1'b0;
    cyc_nx   = wb_cyc_o;
    stb_nx   = wb_stb_o;
    we_nx    = wb_we_o;
    adr_nx   = wb_adr_o;
    sel_nx   = wb_sel_o;
    dat_nx   = wb_dat_o;
`ifdef TIMEOUT_EN
    to_cnt_nx = to_cnt;
`endif

    case (state)
      IDLE: begin
        if (rwi != OP_IDLE) begin
          op_nx   = rwi;
          size_nx = req_sz;
          off_nx  = addr[1:0];
          busy_nx = 1'b1;
          if (req_mis) begin
            // no bus cycle; report the fault while still busy
            state_nx = RESP;
            hold_nx  = 1'b1;
            err_nx   = 1'b1;
            if (rwi != OP_WR) ext_nx = ERR_DATA;
          end else begin
            state_nx = BUS;
            cyc_nx   = 1'b1;
            stb_nx   = 1'b1;
            we_nx    = (rwi == OP_WR);
            adr_nx   = {addr[31:2], 2'b00};
            sel_nx   = req_sel;
            dat_nx   = req_dat;
`ifdef TIMEOUT_EN
            to_cnt_nx = '0;
`endif
          end
        end
      end

      BUS: begin
        if (wb_ack_i) begin
          state_nx = RESP;
          cyc_nx   = 1'b0;
          stb_nx   = 1'b0;
          we_nx    = 1'b0;
          if (op_q == OP_RD) ext_nx = rd_data;
          if (op_q == OP_FE) begin
            instr_nx = wb_dat_i;
            iv_nx    = 1'b1;
          end
        end
`ifdef TIMEOUT_EN
        // an ack in the last allowed cycle still wins over the abort
        else if (to_cnt == CNT_LAST) begin
          state_nx = RESP;
          cyc_nx   = 1'b0;
          stb_nx   = 1'b0;
          we_nx    = 1'b0;
          err_nx   = 1'b1;
          if (op_q != OP_WR) ext_nx = ERR_DATA;
        end else begin
          to_cnt_nx = to_cnt + 1'b1;
        end
`endif
      end

      RESP: begin
        if (hold_q) begin
          hold_nx = 1'b0;
        end else begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      op_q        <= OP_IDLE;
      size_q      <= SZ_B;
      off_q       <= 2'b00;
      hold_q      <= 1'b0;
      busy        <= 1'b0;
      ext_data    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      err         <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= '0;
      wb_dat_o    <= '0;
`ifdef TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      state       <= state_nx;
      op_q        <= op_nx;
      size_q      <= size_nx;
      off_q       <= off_nx;
      hold_q      <= hold_nx;
      busy        <= busy_nx;
      ext_data    <= ext_nx;
      instr       <= instr_nx;
      instr_valid <= iv_nx;
      err         <= err_nx;
      wb_cyc_o    <= cyc_nx;
      wb_stb_o    <= stb_nx;
      wb_we_o     <= we_nx;
      wb_adr_o    <= adr_nx;
      wb_sel_o    <= sel_nx;
      wb_dat_o    <= dat_nx;
`ifdef TIMEOUT_EN
      to_cnt      <= to_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_t07_ext_bus_master.sv
`timescale 1ns/1ps
module tb_t07_ext_bus_master;

  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  rwi;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        busy, instr_valid, err;
  logic [31:0] ext_data, instr;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;

  always #5 clk = ~clk;

  t07_ext_bus_master #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .nrst(nrst), .rwi(rwi), .addr(addr), .wdata(wdata), .size(size),
    .busy(busy), .ext_data(ext_data), .instr(instr), .instr_valid(instr_valid),
    .err(err), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // expected completion as seen at the busy falling edge
  typedef struct { logic [31:0] ext; logic [31:0] ins; int len; int errs; int ivs; } rsp_t;
  // expected bus cycle as seen when cyc rises
  typedef struct { logic [31:0] adr; logic [3:0] sel; logic we; logic [31:0] dat; int len; } bus_t;
  rsp_t rsp_q[$];
  bus_t bus_q[$];

  // reference model state
  logic [31:0] m_ext = '0;
  logic [31:0] m_ins = '0;

  // slave controls
  int          cur_delay = 0;
  logic        fixed_en  = 1'b0;
  logic [31:0] fixed_dat = '0;
  logic        stray     = 1'b0;

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return fixed_en ? fixed_dat : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  // Wishbone slave: acks cur_delay cycles after stb first appears
  initial begin
    int wcnt;
    bit done;
    wcnt = 0; done = 0;
    wb_ack_i = 1'b0; wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = stray;
      if (!wb_cyc_o) begin
        wcnt = 0; done = 0;
      end else if (wb_stb_o && !done) begin
        if (wcnt == cur_delay) begin
          wb_ack_i = 1'b1;
          wb_dat_i = slave_word(wb_adr_o);
          done = 1;
        end else wcnt++;
      end
    end
  end

  // completion monitor
  initial begin
    int blen, ecnt, icnt;
    logic pb;
    rsp_t r;
    blen = 0; ecnt = 0; icnt = 0; pb = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        blen++;
        if (err) ecnt++;
        if (instr_valid) icnt++;
      end else if (pb) begin
        if (rsp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_completion: got busy fall expected none (t=%0t)", $time);
        end else begin
          r = rsp_q.pop_front();
          chk("ext_data", ext_data, r.ext);
          chk("instr", instr, r.ins);
          chk("busy_len", 32'(blen), 32'(r.len));
          chk("err_pulses", 32'(ecnt), 32'(r.errs));
          chk("iv_pulses", 32'(icnt), 32'(r.ivs));
        end
        blen = 0; ecnt = 0; icnt = 0;
      end
      pb = (busy === 1'b1);
    end
  end

  // bus monitor
  initial begin
    int clen;
    logic pc;
    bus_t b;
    logic [31:0] m;
    clen = 0; pc = 1'b0;
    b = '{adr: '0, sel: '0, we: 1'b0, dat: '0, len: 0};
    forever begin
      @(negedge clk);
      if (wb_cyc_o === 1'b1 && !pc) begin
        clen = 1;
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_cyc: got cyc=1 expected no bus cycle (t=%0t)", $time);
        end else begin
          b = bus_q.pop_front();
          chk("wb_adr", wb_adr_o, b.adr);
          chk("wb_sel", {28'h0, wb_sel_o}, {28'h0, b.sel});
          chk("wb_we", {31'h0, wb_we_o}, {31'h0, b.we});
          chk("wb_stb", {31'h0, wb_stb_o}, 32'd1);
          if (b.we) begin
            m = {{8{b.sel[3]}}, {8{b.sel[2]}}, {8{b.sel[1]}}, {8{b.sel[0]}}};
            chk("wb_dat", wb_dat_o & m, b.dat);
          end
        end
      end else if (wb_cyc_o === 1'b1) begin
        clen++;
        chk("wb_adr_stable", wb_adr_o, b.adr);
        chk("wb_sel_stable", {28'h0, wb_sel_o}, {28'h0, b.sel});
      end else if (pc) begin
        chk("cyc_len", 32'(clen), 32'(b.len));
      end
      pc = (wb_cyc_o === 1'b1);
    end
  end

  // wait for busy to fall, spraying ignored requests while busy
  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (busy !== 1'b1) begin
        rwi = 2'b00;
        break;
      end
      rwi = 2'($urandom_range(1, 3));
      addr = $urandom; wdata = $urandom; size = 2'($urandom_range(0, 2));
      n++;
      if (n > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL busy_stuck: got busy=1 for %0d cycles expected completion", n);
        rwi = 2'b00;
        break;
      end
    end
  endtask

  // build expectations from the request rules, then drive the pulse
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input int d);
    rsp_t r;
    bus_t b;
    int esz, off, nbytes;
    logic mis, timed;
    logic [31:0] mask, w;
    esz = (op == 2'b11) ? 2 : int'(sz);
    nbytes = 1 << esz;
    off = (esz == 0) ? int'(a[1:0]) : (esz == 1) ? 2 * int'(a[1]) : 0;
    mis = (a % nbytes) != 0;
    mask = (esz == 2) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
    r.errs = 0; r.ivs = 0; timed = 1'b0;
    if (mis) begin
      r.len = 2; r.errs = 1;
      if (op != 2'b01) m_ext = ERRD;
    end else begin
      b.adr = a & ~32'd3;
      b.we  = (op == 2'b01);
      b.sel = 4'(((1 << nbytes) - 1) << off);
      b.dat = (wd & mask) << (8 * off);
      b.len = d + 1;
`ifdef TIMEOUT_EN
      if (d >= TO) begin
        timed = 1'b1;
        b.len = TO; r.len = TO + 1; r.errs = 1;
        if (op != 2'b01) m_ext = ERRD;
      end
`endif
      if (!timed) begin
        r.len = d + 2;
        w = slave_word(b.adr);
        if (op == 2'b10) m_ext = (w >> (8 * off)) & mask;
        if (op == 2'b11) begin m_ins = w; r.ivs = 1; end
      end
      bus_q.push_back(b);
    end
    r.ext = m_ext; r.ins = m_ins;
    rsp_q.push_back(r);
    cur_delay = d;
    @(posedge clk); #1;
    rwi = op; addr = a; wdata = wd; size = sz;
    @(posedge clk); #1;
    rwi = 2'b00; addr = $urandom; wdata = $urandom; size = 2'($urandom_range(0, 2));
    wait_idle();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected end of test");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rwi = 2'b00; addr = '0; wdata = '0; size = 2'b00; nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_ext", ext_data, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_cyc_stb_we", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_pulses", {30'h0, err, instr_valid}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel_dat", wb_dat_o | {28'h0, wb_sel_o}, 32'd0);
    nrst = 1'b1;

    // directed
    fixed_en = 1'b1;
    fixed_dat = 32'h0050_0093; issue(2'b11, 32'h0000_0100, 32'h0, 2'b00, 2);
    fixed_dat = 32'hAB11_2233; issue(2'b10, 32'h0000_2003, 32'h0, 2'b00, 0);
    issue(2'b01, 32'h0000_3002, 32'h0000_BEEF, 2'b01, 1);
    issue(2'b10, 32'h0000_4001, 32'h0, 2'b10, 0);
    issue(2'b11, 32'h0000_4002, 32'h0, 2'b00, 0);
    issue(2'b10, 32'h0000_5005, 32'h0, 2'b01, 0);
    fixed_dat = 32'hCAFE_F00D; issue(2'b10, 32'h0000_6002, 32'h0, 2'b01, TO - 1);
`ifdef TIMEOUT_EN
    issue(2'b10, 32'h0000_7000, 32'h0, 2'b10, 1000);
    issue(2'b11, 32'h0000_7004, 32'h0, 2'b10, 1000);
`endif

    // reset while in BUS
    fixed_en = 1'b0;
    cur_delay = 20;
    bus_q.push_back('{adr: 32'h0000_8000, sel: 4'hF, we: 1'b0, dat: 32'h0, len: 3});
    m_ext = '0; m_ins = '0;
    rsp_q.push_back('{ext: 32'h0, ins: 32'h0, len: 3, errs: 0, ivs: 0});
    @(posedge clk); #1;
    rwi = 2'b10; addr = 32'h0000_8000; size = 2'b10;
    @(posedge clk); #1;
    rwi = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("post_rst_cyc_busy", {30'h0, wb_cyc_o, busy}, 32'd0);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("stray_ack_busy", {30'h0, wb_cyc_o, busy}, 32'd0);
    chk("stray_ack_ext", ext_data, 32'd0);
    issue(2'b11, 32'h0000_0200, 32'h0, 2'b00, 1);

    // randomized
    for (int i = 0; i < 80; i++) begin
      logic [1:0] op, sz;
      logic [31:0] a;
      op = 2'($urandom_range(1, 3));
      sz = 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << ((op == 2'b11) ? 2 : sz)) - 1);
      issue(op, a, $urandom, sz, $urandom_range(0, 4));
    end

    repeat (4) @(negedge clk);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
